// File: rtl/p6_pkg.sv
// Shared definitions for the P6 decode-stage branch scheduler.
// Holds the compare-code encoding, the scheduler FSM state type and the
// architectural register numbers the scheduler cares about.
package p6_pkg;

   localparam int NUM_REGS = 32;

   // Compare codes carried on br_sel; 110 and 111 are never taken.
   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BGEZ = 3'b010;
   localparam logic [2:0] BR_BGTZ = 3'b011;
   localparam logic [2:0] BR_BLTZ = 3'b100;
   localparam logic [2:0] BR_BLEZ = 3'b101;

   typedef enum logic {
      IDLE    = 1'b0,
      RESOLVE = 1'b1
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator, purely combinational.
// Ports:
//   a, b  : operand values (rs, rt); a is treated as signed for the zero compares
//   sel   : compare code (see p6_pkg BR_*)
//   taken : 1 when the branch condition holds; 0 for unlisted codes
module branch_cmp
   import p6_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  sel,
   output logic        taken
);

   logic a_zero;
   logic a_neg;

   assign a_zero = (a == 32'd0);
   assign a_neg  = a[31];

   always_comb begin
      taken = 1'b0;
      case (sel)
         BR_BEQ:  taken = (a == b);
         BR_BNE:  taken = (a != b);
         BR_BGEZ: taken = ~a_neg;
         BR_BGTZ: taken = ~a_neg & ~a_zero;
         BR_BLTZ: taken = a_neg;
         BR_BLEZ: taken = a_neg | a_zero;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_sched.sv
// Branch scheduler for the decode stage. Holds a branch in ID until its source
// registers are no longer pending from an in-flight producer, evaluates it,
// and one cycle later pulses a redirect (and link write) toward fetch. Also
// owns the per-register write-pending scoreboard.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   flush               : synchronous cancel, highest priority
//   br_valid/br_ready   : branch handshake in ID; stall_id = held branch
//   br_sel, br_rs, br_rt, br_link, rs_val, rt_val, br_target : branch fields
//   wr_valid, wr_addr, wr_lat : producer issue (destination, forward latency)
//   redirect_valid, redirect_pc, link_valid : resolved branch outputs
//   dbg_state           : current FSM state (0 IDLE, 1 RESOLVE)
//
// Handshake: a branch transfers on any rising edge where br_valid & br_ready.
// br_ready never depends on br_valid; the producer must hold all br_* fields
// stable while br_valid is high and br_ready is low.
module branch_sched
   import p6_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        br_valid,
   output logic        br_ready,
   output logic        stall_id,
   input  logic [2:0]  br_sel,
   input  logic [4:0]  br_rs,
   input  logic [4:0]  br_rt,
   input  logic        br_link,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic [31:0] br_target,
   input  logic        wr_valid,
   input  logic [4:0]  wr_addr,
   input  logic [1:0]  wr_lat,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        link_valid,
   output logic        dbg_state
);

   state_e      state_q, state_d;
   logic [1:0]  pend [NUM_REGS];
   logic [1:0]  load_val;
   logic        uses_rt;
   logic        wr_hazard;
   logic        rdy;
   logic        accept;
   logic        cmp_taken;
   logic        taken_q;
   logic        link_q;
   logic [31:0] pc_q;

   branch_cmp u_cmp (
      .a     (rs_val),
      .b     (rt_val),
      .sel   (br_sel),
      .taken (cmp_taken)
   );

   // The counter holds the cycles still outstanding as seen from the cycle
   // after the producer issues, so a latency-L result frees a reader exactly
   // L cycles after issue.
   assign load_val = (wr_lat == 2'd0) ? 2'd0 : wr_lat - 2'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_REGS; r++) pend[r] <= 2'd0;
      end else if (flush) begin
         for (int r = 0; r < NUM_REGS; r++) pend[r] <= 2'd0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_valid && (wr_addr != REG_ZERO) && (wr_addr == 5'(r)))
               pend[r] <= load_val;
            else if (pend[r] != 2'd0)
               pend[r] <= pend[r] - 2'd1;
         end
      end
   end

   assign uses_rt = (br_sel == BR_BEQ) || (br_sel == BR_BNE);

   // A producer issuing in the same cycle is older than the branch; unless
   // its result forwards immediately, the branch must wait for it.
   assign wr_hazard = wr_valid && (wr_lat != 2'd0) && (wr_addr != REG_ZERO) &&
                      ((wr_addr == br_rs) || (uses_rt && (wr_addr == br_rt)));

   assign rdy = (pend[br_rs] == 2'd0) &&
                (!uses_rt || (pend[br_rt] == 2'd0)) &&
                !wr_hazard;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      br_ready = 1'b0;
      case (state_q)
         IDLE: begin
            br_ready = rdy & ~flush;
            if (br_valid & br_ready) state_d = RESOLVE;
         end
         RESOLVE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   assign accept   = br_valid & br_ready;
   assign stall_id = br_valid & ~br_ready & ~flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         taken_q <= 1'b0;
         link_q  <= 1'b0;
         pc_q    <= 32'd0;
      end else if (accept) begin
         taken_q <= cmp_taken;
         link_q  <= br_link;
         pc_q    <= br_target;
      end
   end

   // Pulses come from captured state; flush kills them in the cycle it is
   // raised so a cancelled branch never redirects fetch.
   assign redirect_valid = (state_q == RESOLVE) & taken_q & ~flush;
   assign link_valid     = (state_q == RESOLVE) & link_q & ~flush;
   assign redirect_pc    = pc_q;
   assign dbg_state      = state_q;

endmodule
